// File: rtl/clk_div_rst_gen.sv
// Programmable 50%-duty clock divider with rise/fall strobes and a divided-domain reset hold.
// Optional build macro CLK_DIV_GATE_EN adds Clk_Gate_En to park Clk_Out high.
module clk_div_rst_gen #(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 50,
    parameter int RST_HOLD    = 4,
    parameter int HOLD_W      = 4
) (
    input  logic             Clk,
    input  logic             Rstn,
`ifdef CLK_DIV_GATE_EN
    input  logic             Clk_Gate_En,
`endif
    input  logic [DIV_W-1:0] Half_Period,
    input  logic             Load,
    output logic             Load_Ack,
    output logic             Clk_Out,
    output logic             Rise_Stb,
    output logic             Fall_Stb,
    output logic             Rst_Out
);

    localparam logic [DIV_W-1:0]  HALF_RST = DIV_W'(DIV_DEFAULT);
    localparam logic [HOLD_W:0]   HOLD_TGT = (HOLD_W+1)'(RST_HOLD);

    function automatic logic [DIV_W-1:0] clamp_half(input logic [DIV_W-1:0] v);
        return (v == '0) ? DIV_W'(1) : v;
    endfunction

    logic [1:0]        rst_sync;
    logic              rst_s_n;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  half;
    logic [DIV_W-1:0]  pend_val;
    logic              pend;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W:0]   hold_nxt;
    logic              gate_en;
    logic              at_end;
    logic              park;
    logic              fall_now;
    logic              rise_now;

`ifdef CLK_DIV_GATE_EN
    assign gate_en = Clk_Gate_En;
`else
    assign gate_en = 1'b1;
`endif

    // Assert asynchronously, release after two Clk edges
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_s_n = rst_sync[1];

    // A parked clock only ever sits in its high phase, so a running low phase always finishes
    assign park     = Clk_Out && !gate_en;
    assign at_end   = (cnt == half - DIV_W'(1));
    assign fall_now = at_end && !park && Clk_Out;
    assign rise_now = at_end && !Clk_Out;
    assign hold_nxt = {1'b0, hold_cnt} + (HOLD_W+1)'(1);

    always_ff @(posedge Clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            cnt      <= '0;
            half     <= HALF_RST;
            pend     <= 1'b0;
            hold_cnt <= '0;
            Clk_Out  <= 1'b1;
            Rise_Stb <= 1'b0;
            Fall_Stb <= 1'b0;
            Load_Ack <= 1'b0;
            Rst_Out  <= 1'b1;
        end else begin
            Rise_Stb <= 1'b0;
            Fall_Stb <= 1'b0;
            Load_Ack <= 1'b0;

            if (park) begin
                cnt <= '0;
            end else if (at_end) begin
                cnt     <= '0;
                Clk_Out <= ~Clk_Out;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end

            // New half-period only takes effect at a fall, so the high phase is never altered
            if (fall_now) begin
                Fall_Stb <= 1'b1;
                pend     <= 1'b0;
                if (pend) begin
                    half     <= pend_val;
                    Load_Ack <= 1'b1;
                end
            end
            if (Load) pend <= 1'b1;

            if (rise_now) Rise_Stb <= 1'b1;

            if (RST_HOLD == 0) begin
                Rst_Out <= 1'b0;
            end else if (rise_now && Rst_Out) begin
                hold_cnt <= hold_nxt[HOLD_W-1:0];
                if (hold_nxt == HOLD_TGT) Rst_Out <= 1'b0;
            end
        end
    end

    // Pending value is plain data; it is only consumed while pend is set
    always_ff @(posedge Clk) begin
        if (Load) pend_val <= clamp_half(Half_Period);
    end

endmodule

// File: tb/tb_clk_div_rst_gen.sv
// Directed bench for clk_div_rst_gen with DIV_DEFAULT=50, RST_HOLD=4.
// Expected cycle counts are hand-derived; the gate case is built only with CLK_DIV_GATE_EN.
module tb_clk_div_rst_gen;

    logic       Clk;
    logic       Rstn;
    logic [7:0] Half_Period;
    logic       Load;
    logic       Load_Ack;
    logic       Clk_Out;
    logic       Rise_Stb;
    logic       Fall_Stb;
    logic       Rst_Out;
`ifdef CLK_DIV_GATE_EN
    logic       Clk_Gate_En;
`endif

    int n_chk = 0;
    int n_err = 0;
    int n_ack = 0;

    clk_div_rst_gen #(
        .DIV_W(8), .DIV_DEFAULT(50), .RST_HOLD(4), .HOLD_W(4)
    ) dut (
        .Clk(Clk),
        .Rstn(Rstn),
`ifdef CLK_DIV_GATE_EN
        .Clk_Gate_En(Clk_Gate_En),
`endif
        .Half_Period(Half_Period),
        .Load(Load),
        .Load_Ack(Load_Ack),
        .Clk_Out(Clk_Out),
        .Rise_Stb(Rise_Stb),
        .Fall_Stb(Fall_Stb),
        .Rst_Out(Rst_Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) if (Load_Ack === 1'b1) n_ack++;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycles until the strobe is seen; -1 on timeout
    task automatic wait_fall(output int n);
        n = -1;
        for (int i = 1; i <= 300 && n < 0; i++) begin
            tick();
            if (Fall_Stb === 1'b1) n = i;
        end
    endtask

    task automatic wait_rise(output int n);
        n = -1;
        for (int i = 1; i <= 300 && n < 0; i++) begin
            tick();
            if (Rise_Stb === 1'b1) n = i;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a0;
        Rstn        = 1'b0;
        Load        = 1'b0;
        Half_Period = '0;
`ifdef CLK_DIV_GATE_EN
        Clk_Gate_En = 1'b1;
`endif
        repeat (3) tick();
        check("rst_clk_out", Clk_Out, 1);
        check("rst_rst_out", Rst_Out, 1);
        check("rst_rise", Rise_Stb, 0);
        check("rst_fall", Fall_Stb, 0);
        check("rst_ack", Load_Ack, 0);

        // Release: 2 sync edges + 50-cycle high phase
        Rstn = 1'b1;
        wait_fall(n);
        check("first_fall", n, 52);
        check("first_fall_clk", Clk_Out, 0);
        check("first_fall_rst", Rst_Out, 1);
        tick();
        check("fall_one_cycle", Fall_Stb, 0);
        wait_rise(n);
        check("first_rise", n, 49);
        check("first_rise_clk", Clk_Out, 1);
        for (int k = 2; k <= 4; k++) begin
            wait_fall(n);
            check("per_fall", n, 50);
            check("rst_hold_low", Rst_Out, 1);
            wait_rise(n);
            check("per_rise", n, 50);
            check("rst_hold_rise", Rst_Out, (k == 4) ? 0 : 1);
        end

        // Load 3 ten cycles into a high phase
        repeat (10) tick();
        Half_Period = 8'd3;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        check("ack_early", Load_Ack, 0);
        wait_fall(n);
        check("high_not_cut", n, 39);
        check("ack_with_fall", Load_Ack, 1);
        wait_rise(n);
        check("h3_low", n, 3);
        wait_fall(n);
        check("h3_high", n, 3);
        check("no_extra_ack", Load_Ack, 0);
        wait_rise(n);
        check("h3_low2", n, 3);

        // Load 5 then 7 in one high phase
        Half_Period = 8'd5;
        Load = 1'b1;
        tick();
        Half_Period = 8'd7;
        tick();
        Load = 1'b0;
        a0 = n_ack;
        wait_fall(n);
        check("h3_high2", n, 1);
        check("ack_57", Load_Ack, 1);
        wait_rise(n);
        check("h7_low", n, 7);
        wait_fall(n);
        check("h7_high", n, 7);
        check("ack_57_once", Load_Ack, 0);
        check("ack_count", n_ack - a0, 1);

        // Load at the adopting edge stays pending for the following fall
        wait_rise(n);
        check("h7_low2", n, 7);
        Half_Period = 8'd2;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (5) tick();
        Half_Period = 8'd4;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        check("coin_fall", Fall_Stb, 1);
        check("coin_ack", Load_Ack, 1);
        wait_rise(n);
        check("h2_low", n, 2);
        wait_fall(n);
        check("h2_high", n, 2);
        check("coin_ack2", Load_Ack, 1);
        wait_rise(n);
        check("h4_low", n, 4);

        // Half_Period 0 clamps to 1: toggle every cycle
        Half_Period = 8'd0;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        wait_fall(n);
        check("h4_high", n, 3);
        check("ack_zero", Load_Ack, 1);
        tick();
        check("h1_rise", Rise_Stb, 1);
        check("h1_rise_clk", Clk_Out, 1);
        tick();
        check("h1_fall", Fall_Stb, 1);
        check("h1_fall_clk", Clk_Out, 0);
        check("h1_fall_norise", Rise_Stb, 0);
        tick();
        check("h1_rise2", Rise_Stb, 1);

        // Async reset 20 cycles into a low phase with a Load pending
        Half_Period = 8'd40;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        wait_fall(n);
        check("h40_adopt", n, 2);
        check("h40_ack", Load_Ack, 1);
        repeat (19) tick();
        Half_Period = 8'd9;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        check("pre_rst_clk", Clk_Out, 0);
        check("pre_rst_rst", Rst_Out, 0);
        Rstn = 1'b0;
        #1;
        check("async_clk", Clk_Out, 1);
        check("async_rst", Rst_Out, 1);
        repeat (3) tick();
        Rstn = 1'b1;
        wait_fall(n);
        check("re_fall", n, 52);
        check("pend_discard", Load_Ack, 0);
        wait_rise(n);
        check("re_low", n, 50);
        check("re_hold1", Rst_Out, 1);
        for (int k = 2; k <= 4; k++) begin
            wait_fall(n);
            check("re_per_fall", n, 50);
            wait_rise(n);
            check("re_per_rise", n, 50);
            check("re_hold", Rst_Out, (k == 4) ? 0 : 1);
        end

`ifdef CLK_DIV_GATE_EN
        begin
            int falls;
            int lows;
            falls = 0;
            lows  = 0;
            repeat (10) tick();
            Clk_Gate_En = 1'b0;
            for (int i = 0; i < 300; i++) begin
                tick();
                if (Fall_Stb !== 1'b0) falls++;
                if (Clk_Out !== 1'b1) lows++;
            end
            check("gate_no_fall", falls, 0);
            check("gate_parked_high", lows, 0);
            Clk_Gate_En = 1'b1;
            wait_fall(n);
            check("gate_reenable", n, 50);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
